id_ex_pipe_reg: RTL

//  ID->EX pipeline register. Captures the decoder's control bundle plus the operands, immediate and

---
 rtl/id_ex_pipe_reg_if.sv | 44 ++++
 rtl/id_ex_pipe_reg.sv | 87 ++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX boundary bundle: decoder-side inputs, EX-side registered outputs, hazard/stall controls.
// master = pipeline driving ID fields and EX controls; slave = the pipeline register itself.
interface id_ex_pipe_reg_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [15:0]      id_ctrl;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             ex_flush;
    logic             ex_stall;

    logic             ex_valid;
    logic [15:0]      ex_ctrl;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             hz_stall_id;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, ex_flush, ex_stall,
        input  ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, hz_stall_id, bubble_cnt
    );

    modport slave (
        input  id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, ex_flush, ex_stall,
        output ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, hz_stall_id, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with load-use hazard detection, bubble insertion, flush squash,
// downstream stall hold and a saturating load-use bubble counter.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    id_ex_pipe_reg_if.slave bus
);
    logic             valid_q;
    logic [15:0]      ctrl_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  rs1_data_q;
    logic [XLEN-1:0]  rs2_data_q;
    logic [XLEN-1:0]  imm_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt_q;

    logic uses_rs1;
    logic uses_rs2;
    logic load_use;

    // Conservative operand usage: LUI may raise a false stall, which is harmless.
    always_comb begin
        uses_rs1 = !(bus.id_ctrl[2] && !bus.id_ctrl[8]);
        uses_rs2 = !bus.id_ctrl[6] || bus.id_ctrl[4] || bus.id_ctrl[5];
        load_use = valid_q && ctrl_q[3] && (rd_q != 5'd0) && bus.id_valid &&
                   ((uses_rs1 && (bus.id_rs1 == rd_q)) ||
                    (uses_rs2 && (bus.id_rs2 == rd_q)));
    end

    assign bus.hz_stall_id = bus.ex_stall || (load_use && !bus.ex_flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else if (bus.ex_stall) begin
            // Hold everything; the flush source keeps ex_flush up until the stall clears.
        end else if (bus.ex_flush || load_use || !bus.id_valid) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            if (!bus.ex_flush && load_use && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            valid_q    <= 1'b1;
            ctrl_q     <= bus.id_ctrl;
            pc_q       <= bus.id_pc;
            rs1_data_q <= bus.id_rs1_data;
            rs2_data_q <= bus.id_rs2_data;
            imm_q      <= bus.id_imm;
            rs1_q      <= bus.id_rs1;
            rs2_q      <= bus.id_rs2;
            rd_q       <= bus.id_rd;
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_ctrl     = ctrl_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1_data = rs1_data_q;
    assign bus.ex_rs2_data = rs2_data_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs1      = rs1_q;
    assign bus.ex_rs2      = rs2_q;
    assign bus.ex_rd       = rd_q;
    assign bus.bubble_cnt  = cnt_q;
endmodule
